// File: rtl/uart_tx_arb.sv
// Two-client burst arbiter that feeds a UART TX FIFO and tracks its fill level.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority to client 0; round-robin otherwise.
module uart_tx_arb #(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [WORD_SIZE-1:0] req0_data,
  input  logic                 req0_last,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WORD_SIZE-1:0] req1_data,
  input  logic                 req1_last,
  output logic                 req1_ready,
  output logic [WORD_SIZE-1:0] fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 tx_pop,
  output logic [7:0]           fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 grant_id,
  output logic                 pop_err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] DEPTH     = 8'(FIFO_DEPTH);
  localparam logic [7:0] BEAT_LAST = 8'(BURST_MAX - 1);

  state_t               state, state_next;
  logic [7:0]           beat_cnt;
  logic                 acc0, acc1, accept, acc_last;
  logic [WORD_SIZE-1:0] acc_data;
  logic                 burst_done, pop_ok, enter_gnt, winner;

  assign fifo_full  = (fifo_count == DEPTH);
  assign fifo_empty = (fifo_count == 8'd0);

  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;
  assign acc_data   = acc1 ? req1_data : req0_data;
  assign acc_last   = acc1 ? req1_last : req0_last;
  assign burst_done = accept && (acc_last || (beat_cnt == BEAT_LAST));
  assign pop_ok     = tx_pop && (fifo_count != 8'd0);
  assign enter_gnt  = (state == IDLE) && (state_next != IDLE);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign winner = req0_valid ? 1'b0 : 1'b1;
`else
  // On contention the client that did not hold the last grant wins.
  assign winner = (req0_valid && req1_valid) ? ~grant_id : req1_valid;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if ((req0_valid || req1_valid) && !fifo_full)
              state_next = winner ? GNT1 : GNT0;
      GNT0: if (burst_done || !req0_valid) state_next = IDLE;
      GNT1: if (burst_done || !req1_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (fifo_count < DEPTH) begin
      req0_ready = (state == GNT0);
      req1_ready = (state == GNT1);
    end
  end

  // Count includes the word accepted this cycle even though its write lands next cycle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      fifo_count <= 8'd0;
      grant_id   <= 1'b1;
      beat_cnt   <= 8'd0;
      pop_err    <= 1'b0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) fifo_din <= acc_data;
      fifo_count <= fifo_count + {7'd0, accept} - {7'd0, pop_ok};
      if (enter_gnt) grant_id <= winner;
      if (enter_gnt)   beat_cnt <= 8'd0;
      else if (accept) beat_cnt <= beat_cnt + 8'd1;
      if (tx_pop && (fifo_count == 8'd0)) pop_err <= 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter WORD_SIZE, default 8, SHALL set the width of each data word.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the downstream TX FIFO capacity in words (legal range 1..255).
REQ-003 Parameter BURST_MAX, default 4, SHALL set the maximum number of words accepted per grant (legal range 1..255).
REQ-004 sys_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req0_valid / req1_valid  input  1  client N offers a word.
REQ-007 req0_data / req1_data  input  WORD_SIZE  client N word.
REQ-008 req0_last / req1_last  input  1  client N word is the final one of its burst.
REQ-009 req0_ready / req1_ready  output  1  client N word is accepted this cycle.
REQ-010 fifo_din  output  WORD_SIZE  word written to the TX FIFO.
REQ-011 fifo_wr_en  output  1  single-cycle FIFO write strobe.
REQ-012 tx_pop  input  1  serializer consumed one word from the FIFO this cycle.
REQ-013 fifo_count  output  8  words held or pending in the FIFO.
REQ-014 fifo_full / fifo_empty  output  1  fifo_count==FIFO_DEPTH / fifo_count==0.
REQ-015 grant_id  output  1  client currently or last granted.
REQ-016 pop_err  output  1  sticky flag: tx_pop arrived while fifo_count==0.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1.
REQ-018 reqN_ready SHALL be combinational and high only in state GNTN with fifo_count<FIFO_DEPTH; a word is accepted when reqN_valid && reqN_ready.
REQ-019 An accepted word SHALL appear on fifo_din with fifo_wr_en high exactly one cycle later; fifo_wr_en SHALL be low in all other cycles.
REQ-020 fifo_count SHALL update each cycle as count + accept - (tx_pop && count>0), so acceptance and pop in the same cycle leave it unchanged.
REQ-021 tx_pop with fifo_count==0 SHALL leave fifo_count at 0 and set pop_err until reset.
REQ-022 IDLE -> GNTx SHALL occur when at least one valid is high and fifo_full is low; the winner SHALL be chosen by the policy in REQ-029/030, and grant_id SHALL take the winner's index on that edge.
REQ-023 Words are accepted only in GNT states, so the minimum gap between the first word of one burst and the first word of the next is one IDLE cycle.
REQ-024 The 8-bit beat counter SHALL be cleared on entry to a GNT state and SHALL count accepted words.
REQ-025 GNTx -> IDLE SHALL occur on any of: an accepted word with last=1; the BURST_MAX-th accepted word; reqx_valid low for one cycle.
REQ-026 GNTx SHALL be held while fifo_full is high and reqx_valid is high; no words are accepted during the stall.
REQ-027 With FIFO_DEPTH=1, each write SHALL stall the burst until tx_pop.

Reset
REQ-028 While rst is high, the block SHALL enter IDLE, with fifo_count=0, fifo_empty=1, fifo_full=0, fifo_wr_en=0, fifo_din=0, grant_id=1, pop_err=0, both ready outputs 0 and the beat counter 0; assertion mid-burst SHALL discard any pending write.

Configuration
REQ-029 With macro UART_TX_ARB_FIXED_PRIO_EN defined, client 0 SHALL always win in IDLE when its valid is high.
REQ-030 Without the macro, arbitration SHALL be round-robin: a contended IDLE grant goes to the client other than grant_id (first grant after reset goes to client 0).

Verification
REQ-031 Both valid from reset, no last, FIFO_DEPTH=8, BURST_MAX=4, tx_pop=0 -> client 0 gets 4 words, one IDLE cycle, then client 1 gets 4 words; fifo_count=8 and fifo_full=1.
REQ-032 Client 1 alone sends 3 words, last on the 2nd -> 2 accepted, FSM in IDLE, fifo_wr_en pulses 2 cycles, each one cycle after acceptance.
REQ-033 fifo_count=FIFO_DEPTH, valid held, tx_pop pulsed once -> exactly one word accepted on the cycle after the pop; count returns to FIFO_DEPTH.
REQ-034 tx_pop with count 0 -> count stays 0, pop_err=1 until rst.
REQ-035 rst asserted on the cycle of an acceptance -> no fifo_wr_en pulse, all outputs at reset values asynchronously.
REQ-036 Macro defined, both clients continuously valid -> grant_id stays 0 across 3 consecutive bursts.
